// File: rtl/tight_acc_mat_loader.sv
`default_nettype none
// ============================================================================
// Module   : tight_acc_mat_loader
// Purpose  : Fetches a run of 64B lines, reorders responses by transid and
//            streams 64-bit elements in address order.
// Revision : 1.0
// ============================================================================
module tight_acc_mat_loader #(
  parameter int PADDR_W = 40,
  parameter int NSLOT   = 4,
  parameter int LINE_W  = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_val,
  output logic               start_rdy,
  input  logic [PADDR_W-1:0] start_base,
  input  logic [15:0]        start_nlines,
  output logic               mem_req_val,
  input  logic               mem_req_rdy,
  output logic [5:0]         mem_req_transid,
  output logic [PADDR_W-1:0] mem_req_addr,
  input  logic               mem_resp_val,
  input  logic [5:0]         mem_resp_transid,
  input  logic [LINE_W-1:0]  mem_resp_data,
  output logic               elem_val,
  input  logic               elem_rdy,
  output logic [63:0]        elem_data,
  output logic               elem_last,
  output logic               busy,
  output logic               done,
  output logic               err_bad_tag
);

  localparam int SW = $clog2(NSLOT);
  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;
  localparam logic [PADDR_W-1:0] c_line_mask = ~PADDR_W'(63);

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [PADDR_W-1:0] r_base;
  logic [15:0]        r_nlines;
  logic [15:0]        r_req_cnt;
  logic [15:0]        r_ld_line;
  logic [2:0]         r_ld_idx;
  logic [NSLOT-1:0]   r_inflight;
  logic [NSLOT-1:0]   r_ready;
  logic [LINE_W-1:0]  r_slot_data [NSLOT];
  logic               r_elem_val;
  logic               r_elem_last;
  logic [63:0]        r_elem_data;
  logic [SW-1:0]      r_out_slot;
  logic [2:0]         r_out_idx;
  logic               r_done;
  logic               r_err;

  logic               w_accept;
  logic               w_req_fire;
  logic               w_resp_ok;
  logic               w_capture;
  logic               w_elem_fire;
  logic               w_free;
  logic               w_load;
  logic               w_ld_last;
  logic [SW-1:0]      w_req_slot;
  logic [SW-1:0]      w_resp_slot;
  logic [SW-1:0]      w_ld_slot;

  assign w_accept    = start_val && (r_state == c_st_idle);
  assign w_req_slot  = r_req_cnt[SW-1:0];

  // Request fields are a pure function of registered state, so they hold until the handshake.
  assign mem_req_val     = (r_state == c_st_run) && (r_req_cnt != r_nlines) &&
                           !r_inflight[w_req_slot] && !r_ready[w_req_slot];
  assign mem_req_addr    = mem_req_val ? (r_base + PADDR_W'({r_req_cnt, 6'b0})) : '0;
  assign mem_req_transid = mem_req_val ? 6'(w_req_slot) : 6'd0;
  assign w_req_fire      = mem_req_val && mem_req_rdy;

  assign w_resp_slot = mem_resp_transid[SW-1:0];
  assign w_resp_ok   = (r_state == c_st_run) && ((mem_resp_transid >> SW) == 6'd0) &&
                       r_inflight[w_resp_slot];
  assign w_capture   = mem_resp_val && w_resp_ok;

  assign w_elem_fire = r_elem_val && elem_rdy;
  assign w_free      = w_elem_fire && (r_out_idx == 3'd7);
  assign w_ld_slot   = r_ld_line[SW-1:0];
  assign w_load      = (r_state == c_st_run) && (r_ld_line != r_nlines) &&
                       r_ready[w_ld_slot] && (!r_elem_val || w_elem_fire);
  assign w_ld_last   = (r_ld_line == (r_nlines - 16'd1)) && (r_ld_idx == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_accept && (start_nlines != 16'd0)) w_state_nxt = c_st_run;
      c_st_run:  if (w_elem_fire && r_elem_last)          w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    start_rdy = (r_state == c_st_idle);
    busy      = (r_state != c_st_idle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base      <= '0;
      r_nlines    <= '0;
      r_req_cnt   <= '0;
      r_ld_line   <= '0;
      r_ld_idx    <= '0;
      r_elem_val  <= 1'b0;
      r_elem_last <= 1'b0;
      r_elem_data <= '0;
      r_out_slot  <= '0;
      r_out_idx   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= (w_accept && (start_nlines == 16'd0)) || (w_elem_fire && r_elem_last);
      if (mem_resp_val && !w_resp_ok) r_err <= 1'b1;
      if (w_accept) begin
        r_base    <= start_base & c_line_mask;
        r_nlines  <= start_nlines;
        r_req_cnt <= '0;
        r_ld_line <= '0;
        r_ld_idx  <= '0;
      end
      if (w_req_fire) r_req_cnt <= r_req_cnt + 16'd1;
      if (w_load) begin
        r_elem_val  <= 1'b1;
        r_elem_data <= r_slot_data[w_ld_slot][{r_ld_idx, 6'b0} +: 64];
        r_elem_last <= w_ld_last;
        r_out_slot  <= w_ld_slot;
        r_out_idx   <= r_ld_idx;
        r_ld_idx    <= r_ld_idx + 3'd1;
        if (r_ld_idx == 3'd7) r_ld_line <= r_ld_line + 16'd1;
      end else if (w_elem_fire) begin
        r_elem_val  <= 1'b0;
        r_elem_last <= 1'b0;
      end
    end
  end

  // A slot is never in-flight and ready at once, so the three updates never collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_ready    <= '0;
    end else begin
      for (int j = 0; j < NSLOT; j++) begin
        if (w_req_fire && (w_req_slot == SW'(j))) r_inflight[j] <= 1'b1;
        if (w_capture && (w_resp_slot == SW'(j))) begin
          r_inflight[j] <= 1'b0;
          r_ready[j]    <= 1'b1;
        end
        if (w_free && (r_out_slot == SW'(j))) r_ready[j] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < NSLOT; j++) begin
      if (w_capture && (w_resp_slot == SW'(j))) r_slot_data[j] <= mem_resp_data;
    end
  end

  assign elem_val    = r_elem_val;
  assign elem_data   = r_elem_data;
  assign elem_last   = r_elem_last;
  assign done        = r_done;
  assign err_bad_tag = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tight_acc_mat_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_tight_acc_mat_loader
// Purpose  : Directed self-checking bench for tight_acc_mat_loader.
// Revision : 1.0
// ============================================================================
module tb_tight_acc_mat_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_val;
  logic         start_rdy;
  logic [39:0]  start_base;
  logic [15:0]  start_nlines;
  logic         mem_req_val;
  logic         mem_req_rdy;
  logic [5:0]   mem_req_transid;
  logic [39:0]  mem_req_addr;
  logic         mem_resp_val;
  logic [5:0]   mem_resp_transid;
  logic [511:0] mem_resp_data;
  logic         elem_val;
  logic         elem_rdy;
  logic [63:0]  elem_data;
  logic         elem_last;
  logic         busy;
  logic         done;
  logic         err_bad_tag;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] got_data [128];
  logic        got_last [128];
  int          n_got;
  logic [39:0] req_addr [32];
  logic [5:0]  req_tid  [32];
  int          n_req;
  int          max_out;
  int          stall_viol;
  int          done_gap;
  int          done_count;
  int          first_hs;
  int          last_hs;
  bit          timed_out;

  always #5 clk = ~clk;

  tight_acc_mat_loader #(.PADDR_W(40), .NSLOT(4), .LINE_W(512)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_val(start_val), .start_rdy(start_rdy), .start_base(start_base), .start_nlines(start_nlines),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_transid(mem_req_transid),
    .mem_req_addr(mem_req_addr), .mem_resp_val(mem_resp_val), .mem_resp_transid(mem_resp_transid),
    .mem_resp_data(mem_resp_data), .elem_val(elem_val), .elem_rdy(elem_rdy), .elem_data(elem_data),
    .elem_last(elem_last), .busy(busy), .done(done), .err_bad_tag(err_bad_tag)
  );

  function automatic logic [63:0] elem_word(input int li, input int k);
    return {16'hBEEF, li[15:0], 29'd0, k[2:0]};
  endfunction

  task automatic drive_line(input logic [5:0] tid, input int li);
    mem_resp_val     = 1'b1;
    mem_resp_transid = tid;
    for (int k = 0; k < 8; k++) mem_resp_data[64*k +: 64] = elem_word(li, k);
  endtask

  // Runs one command; mode 0 = in-order responses, mode 1 = responses in order 3,1,0,2.
  task automatic run_load(input logic [39:0] base, input int nl, input int mode,
                          input bit toggle_rdy, input int rdy_pct);
    int pend[$];
    int order[4];
    int oi, cyc, done_cyc, lines_done, idx, li;
    bit e_stall, r_stall, finished;
    logic [63:0] sd;
    logic sl;
    logic [39:0] sa;
    logic [5:0] st;
    order = '{3, 1, 0, 2};
    n_got = 0; n_req = 0; max_out = 0; stall_viol = 0; done_count = 0;
    first_hs = -1; last_hs = -100; done_cyc = -200; oi = 0; lines_done = 0;
    e_stall = 0; r_stall = 0; finished = 0; cyc = 0;
    @(negedge clk);
    start_val = 1'b1; start_base = base; start_nlines = 16'(nl);
    mem_req_rdy = 1'b1; elem_rdy = 1'b1; mem_resp_val = 1'b0;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      start_val = 1'b0;
      if (done) begin done_count++; done_cyc = cyc; end
      if (e_stall && (!elem_val || elem_data !== sd || elem_last !== sl)) stall_viol++;
      if (r_stall && (!mem_req_val || mem_req_addr !== sa || mem_req_transid !== st)) stall_viol++;
      mem_resp_val = 1'b0;
      if (mode == 0 && pend.size() > 0) begin
        idx = pend.pop_front();
        li  = int'((req_addr[idx] - base) >> 6);
        drive_line(req_tid[idx], li);
      end else if (mode == 1 && n_req == nl && oi < nl && oi < 4) begin
        idx = order[oi]; oi++;
        li  = int'((req_addr[idx] - base) >> 6);
        drive_line(req_tid[idx], li);
      end
      mem_req_rdy = toggle_rdy ? ~mem_req_rdy : 1'b1;
      elem_rdy    = ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (mem_req_val && mem_req_rdy && n_req < 32) begin
        req_addr[n_req] = mem_req_addr; req_tid[n_req] = mem_req_transid;
        pend.push_back(n_req); n_req++;
      end
      r_stall = mem_req_val && !mem_req_rdy;
      sa = mem_req_addr; st = mem_req_transid;
      if (elem_val && elem_rdy && n_got < 128) begin
        got_data[n_got] = elem_data; got_last[n_got] = elem_last; n_got++;
        if (n_got % 8 == 0) lines_done++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      e_stall = elem_val && !elem_rdy;
      sd = elem_data; sl = elem_last;
      if (n_req - lines_done > max_out) max_out = n_req - lines_done;
      if (done_count > 0 && cyc >= done_cyc + 2) finished = 1;
      cyc++;
    end
    timed_out = !finished;
    done_gap  = done_cyc - last_hs;
    mem_resp_val = 1'b0; mem_req_rdy = 1'b1; elem_rdy = 1'b1;
  endtask

  task automatic test_reset;
    n_vec++; if (start_rdy !== 1'b1) begin n_err++; $display("FAIL rst_start_rdy got %b want 1", start_rdy); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0 || err_bad_tag !== 1'b0) begin n_err++;
      $display("FAIL rst_flags got busy=%b done=%b err=%b want 0 0 0", busy, done, err_bad_tag); end
    rst_n = 1'b1;
    @(negedge clk);
    start_val = 1'b1; start_base = 40'h2000; start_nlines = 16'd4; mem_req_rdy = 1'b1;
    @(negedge clk);
    start_val = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL run_busy got %b want 1", busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (mem_req_val !== 1'b0 || elem_val !== 1'b0 || elem_last !== 1'b0) begin n_err++;
      $display("FAIL midrun_rst_vals got req=%b ev=%b el=%b want 0 0 0", mem_req_val, elem_val, elem_last); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0 || err_bad_tag !== 1'b0 || start_rdy !== 1'b1) begin n_err++;
      $display("FAIL midrun_rst_flags got busy=%b done=%b err=%b rdy=%b want 0 0 0 1", busy, done, err_bad_tag, start_rdy); end
    n_vec++; if (mem_req_addr !== 40'd0 || mem_req_transid !== 6'd0 || elem_data !== 64'd0) begin n_err++;
      $display("FAIL midrun_rst_fields got addr=%h tid=%h data=%h want 0", mem_req_addr, mem_req_transid, elem_data); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (start_rdy !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_req_val !== 1'b0) begin n_err++;
      $display("FAIL post_rst got rdy=%b busy=%b done=%b req=%b want 1 0 0 0", start_rdy, busy, done, mem_req_val); end
    drive_line(6'd1, 0);
    @(negedge clk);
    mem_resp_val = 1'b0;
    n_vec++; if (err_bad_tag !== 1'b1) begin n_err++; $display("FAIL late_resp_err got %b want 1", err_bad_tag); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++; if (err_bad_tag !== 1'b0) begin n_err++; $display("FAIL err_cleared got %b want 0", err_bad_tag); end
  endtask

  task automatic test_basic;
    run_load(40'h1000, 2, 0, 1'b0, 100);
    n_vec++; if (timed_out) begin n_err++; $display("FAIL basic_timeout got timeout want done"); end
    n_vec++; if (n_req !== 2 || req_addr[0] !== 40'h1000 || req_addr[1] !== 40'h1040) begin n_err++;
      $display("FAIL basic_addrs got n=%0d a0=%h a1=%h want 2 1000 1040", n_req, req_addr[0], req_addr[1]); end
    n_vec++; if (req_tid[0] !== 6'd0 || req_tid[1] !== 6'd1) begin n_err++;
      $display("FAIL basic_tids got %h %h want 0 1", req_tid[0], req_tid[1]); end
    n_vec++; if (n_got !== 16) begin n_err++; $display("FAIL basic_count got %0d want 16", n_got); end
    for (int i = 0; i < n_got; i++) begin
      n_vec++;
      if (got_data[i] !== elem_word(i / 8, i % 8) || got_last[i] !== (i == 15)) begin n_err++;
        $display("FAIL basic_elem[%0d] got %h last=%b want %h last=%b", i, got_data[i], got_last[i], elem_word(i / 8, i % 8), i == 15); end
    end
    n_vec++; if (last_hs - first_hs !== 15) begin n_err++; $display("FAIL basic_no_bubble got span %0d want 15", last_hs - first_hs); end
    n_vec++; if (done_gap !== 1 || done_count !== 1) begin n_err++;
      $display("FAIL basic_done got gap=%0d pulses=%0d want 1 1", done_gap, done_count); end
  endtask

  task automatic test_zero_lines;
    @(negedge clk);
    start_val = 1'b1; start_base = 40'h3000; start_nlines = 16'd0;
    @(negedge clk);
    start_val = 1'b0;
    n_vec++; if (done !== 1'b1 || busy !== 1'b0 || mem_req_val !== 1'b0) begin n_err++;
      $display("FAIL zero_done got done=%b busy=%b req=%b want 1 0 0", done, busy, mem_req_val); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_pulse got %b want 0", done); end
  endtask

  task automatic test_reorder;
    run_load(40'h8000, 4, 1, 1'b0, 100);
    n_vec++; if (timed_out || n_req !== 4 || n_got !== 32) begin n_err++;
      $display("FAIL reorder_counts got to=%b reqs=%0d elems=%0d want 0 4 32", timed_out, n_req, n_got); end
    for (int i = 0; i < n_req && i < 4; i++) begin
      n_vec++;
      if (req_addr[i] !== 40'h8000 + 40'(64 * i) || req_tid[i] !== 6'(i)) begin n_err++;
        $display("FAIL reorder_req[%0d] got %h/%h want %h/%h", i, req_addr[i], req_tid[i], 40'h8000 + 40'(64 * i), 6'(i)); end
    end
    for (int i = 0; i < n_got; i++) begin
      n_vec++;
      if (got_data[i] !== elem_word(i / 8, i % 8) || got_last[i] !== (i == 31)) begin n_err++;
        $display("FAIL reorder_elem[%0d] got %h last=%b want %h", i, got_data[i], got_last[i], elem_word(i / 8, i % 8)); end
    end
    n_vec++; if (done_gap !== 1 || done_count !== 1) begin n_err++;
      $display("FAIL reorder_done got gap=%0d pulses=%0d want 1 1", done_gap, done_count); end
  endtask

  task automatic test_back_to_back_stall;
    run_load(40'hA_0000_0040, 9, 0, 1'b1, 100);
    n_vec++; if (timed_out || n_req !== 9 || n_got !== 72) begin n_err++;
      $display("FAIL stall_counts got to=%b reqs=%0d elems=%0d want 0 9 72", timed_out, n_req, n_got); end
    n_vec++; if (max_out > 4) begin n_err++; $display("FAIL stall_inflight got %0d want <=4", max_out); end
    n_vec++; if (stall_viol !== 0) begin n_err++; $display("FAIL stall_stable got %0d changes want 0", stall_viol); end
    for (int i = 0; i < n_req && i < 9; i++) begin
      n_vec++;
      if (req_addr[i] !== 40'hA_0000_0040 + 40'(64 * i) || req_tid[i] !== 6'(i % 4)) begin n_err++;
        $display("FAIL stall_req[%0d] got %h/%h want %h/%h", i, req_addr[i], req_tid[i], 40'hA_0000_0040 + 40'(64 * i), 6'(i % 4)); end
    end
    for (int i = 0; i < n_got; i++) begin
      n_vec++;
      if (got_data[i] !== elem_word(i / 8, i % 8) || got_last[i] !== (i == 71)) begin n_err++;
        $display("FAIL stall_elem[%0d] got %h last=%b want %h", i, got_data[i], got_last[i], elem_word(i / 8, i % 8)); end
    end
  endtask

  task automatic test_random_rdy;
    run_load(40'h5000, 3, 0, 1'b0, 30);
    n_vec++; if (timed_out || n_got !== 24) begin n_err++;
      $display("FAIL rand_count got to=%b elems=%0d want 0 24", timed_out, n_got); end
    n_vec++; if (stall_viol !== 0) begin n_err++; $display("FAIL rand_stable got %0d changes want 0", stall_viol); end
    for (int i = 0; i < n_got; i++) begin
      n_vec++;
      if (got_data[i] !== elem_word(i / 8, i % 8) || got_last[i] !== (i == 23)) begin n_err++;
        $display("FAIL rand_elem[%0d] got %h last=%b want %h", i, got_data[i], got_last[i], elem_word(i / 8, i % 8)); end
    end
    n_vec++; if (done_gap !== 1 || done_count !== 1) begin n_err++;
      $display("FAIL rand_done got gap=%0d pulses=%0d want 1 1", done_gap, done_count); end
  endtask

  task automatic test_bad_tag;
    int ne;
    bit dn;
    @(negedge clk);
    start_val = 1'b1; start_base = 40'h4000; start_nlines = 16'd1; mem_req_rdy = 1'b0; elem_rdy = 1'b0;
    @(negedge clk);
    start_val = 1'b0;
    drive_line(6'h21, 0);
    @(negedge clk);
    mem_resp_val = 1'b0;
    n_vec++; if (err_bad_tag !== 1'b1 || elem_val !== 1'b0) begin n_err++;
      $display("FAIL tag_upper got err=%b ev=%b want 1 0", err_bad_tag, elem_val); end
    repeat (3) @(negedge clk);
    n_vec++; if (err_bad_tag !== 1'b1) begin n_err++; $display("FAIL tag_sticky got %b want 1", err_bad_tag); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_val = 1'b1; start_base = 40'h4000; start_nlines = 16'd1;
    @(negedge clk);
    start_val = 1'b0;
    drive_line(6'd2, 0);
    @(negedge clk);
    mem_resp_val = 1'b0;
    n_vec++; if (err_bad_tag !== 1'b1) begin n_err++; $display("FAIL tag_free_slot got %b want 1", err_bad_tag); end
    mem_req_rdy = 1'b1;
    #1;
    n_vec++; if (mem_req_val !== 1'b1 || mem_req_addr !== 40'h4000 || mem_req_transid !== 6'd0) begin n_err++;
      $display("FAIL tag_req got v=%b a=%h t=%h want 1 4000 0", mem_req_val, mem_req_addr, mem_req_transid); end
    @(negedge clk);
    mem_req_rdy = 1'b0;
    drive_line(6'd0, 0);
    @(negedge clk);
    mem_resp_val = 1'b0; elem_rdy = 1'b1;
    ne = 0; dn = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) dn = 1;
      #1;
      if (elem_val) begin
        n_vec++;
        if (elem_data !== elem_word(0, ne) || elem_last !== (ne == 7)) begin n_err++;
          $display("FAIL tag_elem[%0d] got %h want %h", ne, elem_data, elem_word(0, ne)); end
        ne++;
      end
    end
    n_vec++; if (ne !== 8 || !dn || err_bad_tag !== 1'b1) begin n_err++;
      $display("FAIL tag_finish got elems=%0d done=%b err=%b want 8 1 1", ne, dn, err_bad_tag); end
    mem_req_rdy = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start_val = 1'b0; start_base = '0; start_nlines = '0;
    mem_req_rdy = 1'b1; mem_resp_val = 1'b0; mem_resp_transid = '0; mem_resp_data = '0;
    elem_rdy = 1'b1;
    repeat (3) @(negedge clk);
    test_reset;
    test_basic;
    test_zero_lines;
    test_reorder;
    test_back_to_back_stall;
    test_random_rdy;
    test_bad_tag;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
